// File: rtl/motor_step_gen_multi.sv
// motor_step_gen_multi
//
// Multi-axis step/dir pulse generator. N_CH independent channels share one set
// of pulse timing thresholds. Each channel buffers step requests that arrive
// mid-pulse in a small FIFO, tracks a signed position, and supports
// set-position, per-channel flush and a global hold snapshot.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pre_n_i           counter value at which step goes high (low CNT_BITS used)
//   pulse_n_i         counter value at which step goes low
//   post_n_i          counter value that ends the step period
//   step_stb_i        per-channel one-cycle step request
//   step_dir_i        request direction, 1 = negative
//   invert_dir_i      per-channel dir pin polarity
//   flush_i           abort current step and empty the queue
//   set_x_i, x_val_i  load position (channel i uses x_val_i[i*X_BITS +: X_BITS])
//   hold_i            snapshot all positions into x_hold_o
//   step_o, dir_o     registered driver pins
//   missed_o          strobe dropped because the queue was full (same cycle)
//   busy_o            counter running or queue not empty
//   q_full_o          queue holds QDEPTH entries
//   x_o, x_hold_o     signed positions and their last snapshot
module motor_step_gen_multi #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned X_BITS   = 24,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pre_n_i,
    input  logic [31:0]              pulse_n_i,
    input  logic [31:0]              post_n_i,
    input  logic [N_CH-1:0]          step_stb_i,
    input  logic [N_CH-1:0]          step_dir_i,
    input  logic [N_CH-1:0]          invert_dir_i,
    input  logic [N_CH-1:0]          flush_i,
    input  logic [N_CH-1:0]          set_x_i,
    input  logic [N_CH*X_BITS-1:0]   x_val_i,
    input  logic                     hold_i,
    output logic [N_CH-1:0]          step_o,
    output logic [N_CH-1:0]          dir_o,
    output logic [N_CH-1:0]          missed_o,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          q_full_o,
    output logic [N_CH*X_BITS-1:0]   x_o,
    output logic [N_CH*X_BITS-1:0]   x_hold_o
);

    localparam int unsigned OccW = $clog2(QDEPTH + 1);
    localparam logic [OccW-1:0] OccFull = OccW'(QDEPTH);

    // Shared timing thresholds, truncated to the counter width.
    logic [CNT_BITS-1:0] pre_c, pulse_c, post_c;
    assign pre_c   = pre_n_i[CNT_BITS-1:0];
    assign pulse_c = pulse_n_i[CNT_BITS-1:0];
    assign post_c  = post_n_i[CNT_BITS-1:0];

    if (CNT_BITS < 32) begin : g_unused_hi
        logic unused_timing_hi;
        assign unused_timing_hi = ^{pre_n_i[31:CNT_BITS], pulse_n_i[31:CNT_BITS],
                                    post_n_i[31:CNT_BITS]};
    end

    // State
    logic [CNT_BITS-1:0] cnt_q    [N_CH];
    logic [CNT_BITS-1:0] cnt_d    [N_CH];
    logic [OccW-1:0]     occ_q    [N_CH];
    logic [OccW-1:0]     occ_d    [N_CH];
    logic [QDEPTH-1:0]   fifo_q   [N_CH];   // head at bit 0
    logic [QDEPTH-1:0]   fifo_d   [N_CH];
    logic [X_BITS-1:0]   x_q      [N_CH];
    logic [X_BITS-1:0]   x_d      [N_CH];
    logic [X_BITS-1:0]   x_hold_q [N_CH];
    logic [X_BITS-1:0]   x_hold_d [N_CH];
    logic [N_CH-1:0]     step_q, step_d;
    logic [N_CH-1:0]     dir_q, dir_d;

    // Per-channel decode
    logic [N_CH-1:0] idle, pop, bypass, start, req_dir, push, accept, drop;

    // Scratch for the FIFO update
    logic [QDEPTH-1:0] fifo_shift [N_CH];
    logic [OccW-1:0]   occ_pop    [N_CH];

    always_comb begin
        idle    = '0;
        pop     = '0;
        bypass  = '0;
        start   = '0;
        req_dir = '0;
        push    = '0;
        accept  = '0;
        drop    = '0;
        for (int i = 0; i < N_CH; i++) begin
            idle[i]    = (cnt_q[i] == '0);
            // A queued request always has priority over a new strobe.
            pop[i]     = idle[i] & (occ_q[i] != '0) & ~flush_i[i];
            bypass[i]  = idle[i] & (occ_q[i] == '0) & step_stb_i[i] & ~flush_i[i];
            start[i]   = pop[i] | bypass[i];
            req_dir[i] = pop[i] ? fifo_q[i][0] : step_dir_i[i];
            push[i]    = step_stb_i[i] & ~bypass[i] & ~flush_i[i];
            // Occupancy is judged before any same-cycle pop.
            accept[i]  = push[i] & (occ_q[i] != OccFull);
            drop[i]    = push[i] & (occ_q[i] == OccFull);
        end
    end

    // Queue next state
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            fifo_shift[i] = pop[i] ? (fifo_q[i] >> 1) : fifo_q[i];
            occ_pop[i]    = occ_q[i] - OccW'(pop[i]);
            fifo_d[i]     = fifo_shift[i];
            occ_d[i]      = occ_pop[i] + OccW'(accept[i]);
            if (accept[i]) begin
                for (int k = 0; k < QDEPTH; k++) begin
                    if (occ_pop[i] == OccW'(k)) begin
                        fifo_d[i][k] = step_dir_i[i];
                    end
                end
            end
            if (flush_i[i]) begin
                occ_d[i] = '0;
            end
        end
    end

    // Counter, pins and position next state
    always_comb begin
        step_d = '0;
        dir_d  = dir_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            x_d[i]      = x_q[i];
            x_hold_d[i] = hold_i ? x_q[i] : x_hold_q[i];

            if (flush_i[i]) begin
                cnt_d[i] = '0;
            end else if (idle[i]) begin
                if (start[i]) begin
                    cnt_d[i] = CNT_BITS'(1);
                end
            end else if (cnt_q[i] < pre_c) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end else if (cnt_q[i] < pulse_c) begin
                step_d[i] = 1'b1;
                cnt_d[i]  = cnt_q[i] + CNT_BITS'(1);
            end else if (cnt_q[i] < post_c) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end else begin
                cnt_d[i] = '0;
            end

            if (start[i]) begin
                dir_d[i] = req_dir[i] ^ invert_dir_i[i];
                x_d[i]   = req_dir[i] ? (x_q[i] - X_BITS'(1)) : (x_q[i] + X_BITS'(1));
            end
            // A load wins over the start's position update; the start still runs.
            if (set_x_i[i]) begin
                x_d[i] = x_val_i[i*X_BITS +: X_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                occ_q[i]    <= '0;
                fifo_q[i]   <= '0;
                x_q[i]      <= '0;
                x_hold_q[i] <= '0;
            end
            step_q <= '0;
            dir_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
            fifo_q   <= fifo_d;
            x_q      <= x_d;
            x_hold_q <= x_hold_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
        end
    end

    // Outputs
    always_comb begin
        step_o   = step_q;
        dir_o    = dir_q;
        missed_o = drop & {N_CH{~reset}};
        busy_o   = '0;
        q_full_o = '0;
        x_o      = '0;
        x_hold_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy_o[i]                   = (cnt_q[i] != '0) | (occ_q[i] != '0);
            q_full_o[i]                 = (occ_q[i] == OccFull);
            x_o[i*X_BITS +: X_BITS]      = x_q[i];
            x_hold_o[i*X_BITS +: X_BITS] = x_hold_q[i];
        end
    end

endmodule
